// File: rtl/clock_phase_scheduler_if.sv
// Divide-ratio configuration channel for clock_phase_scheduler.
// The master offers a ratio (cfg_valid/cfg_div); the scheduler answers with
// cfg_ready (no ratio pending) and a one-cycle cfg_err when it rejects a ratio.
interface clock_phase_scheduler_if #(
  parameter int CNT_W = 32
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );
endinterface

// File: rtl/clock_phase_scheduler.sv
// Two-phase clock scheduler: derives phase1/phase2 levels and en1/en2 pulses
// from clk_in with a run-time programmable period, and sequences the core
// through HALT, free-running RUN, single-period STEP and STOPPING.
// A new ratio is held as "pending" and only applied in HALT or on the wrap
// (cnt == div-1 -> 0), so one period never mixes two ratios.
// Optional macro PERIOD_COUNT_EN adds a 32-bit completed-period counter
// output (period_cnt), cleared whenever a new ratio is applied.
module clock_phase_scheduler #(
  parameter int CNT_W       = 32,
  parameter int DIV_DEFAULT = 100,
  parameter int DIV_MIN     = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  clock_phase_scheduler_if.slave  cfg,
  input  logic                    run,
  input  logic                    step,
  input  logic                    halt_req,
  output logic                    phase1,
  output logic                    phase2,
  output logic                    en1,
  output logic                    en2,
`ifdef PERIOD_COUNT_EN
  output logic [31:0]             period_cnt,
`endif
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_HALT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STEP     = 2'd2,
    ST_STOPPING = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DIV_DEFAULT_C = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] DIV_MIN_C     = CNT_W'(DIV_MIN);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] pend_r;
  logic             pend_valid_r;
  logic             run_armed_r;
  logic             cfg_err_r;
  logic             phase1_r;
  logic             phase2_r;
  logic             en1_r;
  logic             en2_r;

  logic             active_s;
  logic             wrap_s;
  logic             offer_s;
  logic             accept_s;
  logic             reject_s;
  logic             apply_s;
  logic [CNT_W-1:0] half_s;
  logic [CNT_W-1:0] quarter_s;
  logic [CNT_W-1:0] three_q_s;
  logic             phase1_s;
  logic             phase2_s;
  logic             en1_s;
  logic             en2_s;

  // Period decode: thresholds use truncating division, wrap ends the period.
  assign active_s  = (state_r != ST_HALT);
  assign wrap_s    = active_s && (cnt_r == (div_r - CNT_W'(1)));
  assign half_s    = div_r >> 1;
  assign quarter_s = div_r >> 2;
  assign three_q_s = quarter_s + (quarter_s << 1);

  // Config handshake: ready only with an empty pending slot; small ratios bounce.
  assign offer_s  = cfg.cfg_valid && !pend_valid_r;
  assign accept_s = offer_s && (cfg.cfg_div >= DIV_MIN_C);
  assign reject_s = offer_s && (cfg.cfg_div < DIV_MIN_C);
  assign apply_s  = pend_valid_r && (!active_s || wrap_s);

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_HALT;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; run wins over step, STEP/STOPPING finish their period.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_HALT: begin
        if (run && run_armed_r) begin
          state_s = ST_RUN;
        end else if (step && !run) begin
          state_s = ST_STEP;
        end else begin
          state_s = ST_HALT;
        end
      end
      ST_RUN: begin
        if (halt_req || !run) begin
          state_s = ST_STOPPING;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_STEP, ST_STOPPING: begin
        if (wrap_s) begin
          state_s = ST_HALT;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_HALT;
    endcase
  end

  // FSM output decode: phase levels and pulses for the current count, zero in HALT.
  always_comb begin
    phase1_s = 1'b0;
    phase2_s = 1'b0;
    en1_s    = 1'b0;
    en2_s    = 1'b0;
    if (active_s) begin
      phase1_s = (cnt_r < half_s);
      phase2_s = (cnt_r < three_q_s);
      en1_s    = (cnt_r == {CNT_W{1'b0}});
      en2_s    = (cnt_r == half_s);
    end else begin
      phase1_s = 1'b0;
      phase2_s = 1'b0;
      en1_s    = 1'b0;
      en2_s    = 1'b0;
    end
  end

  // Period counter: free counts 0..div-1 while active, parked at 0 in HALT.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!active_s || wrap_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  // Ratio storage: latch an accepted ratio as pending, move it to div at a boundary.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_r        <= DIV_DEFAULT_C;
      pend_r       <= {CNT_W{1'b0}};
      pend_valid_r <= 1'b0;
      cfg_err_r    <= 1'b0;
    end else begin
      cfg_err_r <= reject_s;
      if (apply_s) begin
        div_r        <= pend_r;
        pend_valid_r <= 1'b0;
      end else if (accept_s) begin
        pend_r       <= cfg.cfg_div;
        pend_valid_r <= 1'b1;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  // Restart guard: after a halt_req stop, run must drop before RUN may start again.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      run_armed_r <= 1'b1;
    end else if (!run) begin
      run_armed_r <= 1'b1;
    end else if ((state_r == ST_RUN) && halt_req) begin
      run_armed_r <= 1'b0;
    end else begin
      run_armed_r <= run_armed_r;
    end
  end

  // Output registers: phase outputs lag the counter by one cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      phase1_r <= 1'b0;
      phase2_r <= 1'b0;
      en1_r    <= 1'b0;
      en2_r    <= 1'b0;
    end else begin
      phase1_r <= phase1_s;
      phase2_r <= phase2_s;
      en1_r    <= en1_s;
      en2_r    <= en2_s;
    end
  end

`ifdef PERIOD_COUNT_EN
  logic [31:0] period_cnt_r;

  // Completed-period counter, restarted whenever a new ratio takes effect.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      period_cnt_r <= 32'd0;
    end else if (apply_s) begin
      period_cnt_r <= 32'd0;
    end else if (wrap_s) begin
      period_cnt_r <= period_cnt_r + 32'd1;
    end else begin
      period_cnt_r <= period_cnt_r;
    end
  end

  assign period_cnt = period_cnt_r;
`endif

  assign phase1        = phase1_r;
  assign phase2        = phase2_r;
  assign en1           = en1_r;
  assign en2           = en2_r;
  assign busy          = active_s;
  assign cfg.cfg_ready = !pend_valid_r;
  assign cfg.cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_clock_phase_scheduler.sv
// Self-checking bench for clock_phase_scheduler: a period-level reference
// model compared every cycle, plus directed scenarios with literal counts.
`timescale 1ns/1ps
module tb_clock_phase_scheduler;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic run = 1'b0;
  logic step = 1'b0;
  logic halt_req = 1'b0;
  logic phase1, phase2, en1, en2, busy;
`ifdef PERIOD_COUNT_EN
  logic [31:0] period_cnt;
`endif

  clock_phase_scheduler_if #(.CNT_W(CNT_W)) cfg_if ();

  clock_phase_scheduler #(.CNT_W(CNT_W), .DIV_DEFAULT(100), .DIV_MIN(2)) dut (
    .clk_in   (clk),
    .rst_n    (rst_n),
    .cfg      (cfg_if),
    .run      (run),
    .step     (step),
    .halt_req (halt_req),
    .phase1   (phase1),
    .phase2   (phase2),
    .en1      (en1),
    .en2      (en2),
`ifdef PERIOD_COUNT_EN
    .period_cnt (period_cnt),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 halted, 1 running, 2 single period, 3 finishing.
  int          m_mode = 0;
  logic [31:0] m_pos = 0, m_len = 100, m_next_len = 0, m_pc = 0;
  bit          m_has_next = 0, m_may_start = 1;
  bit          m_p1 = 0, m_p2 = 0, m_e1 = 0, m_e2 = 0, m_err = 0;
  bit          m_act, m_end, m_offer;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pos = 0; m_len = 100; m_next_len = 0; m_pc = 0;
      m_has_next = 0; m_may_start = 1;
      m_p1 = 0; m_p2 = 0; m_e1 = 0; m_e2 = 0; m_err = 0;
    end else begin
      m_act   = (m_mode != 0);
      m_end   = m_act && (m_pos == m_len - 1);
      m_offer = cfg_if.cfg_valid && !m_has_next;
      m_p1  = m_act && (m_pos < m_len / 2);
      m_p2  = m_act && (m_pos < (m_len / 4) * 3);
      m_e1  = m_act && (m_pos == 0);
      m_e2  = m_act && (m_pos == m_len / 2);
      m_err = m_offer && (cfg_if.cfg_div < 2);
      if (m_has_next && (!m_act || m_end)) begin
        m_len = m_next_len; m_has_next = 0; m_pc = 0;
      end else if (m_end) begin
        m_pc = m_pc + 1;
      end
      if (m_offer && cfg_if.cfg_div >= 2) begin
        m_has_next = 1; m_next_len = cfg_if.cfg_div;
      end
      m_pos = (m_act && !m_end) ? m_pos + 1 : 0;
      if (!run) m_may_start = 1;
      else if (m_mode == 1 && halt_req) m_may_start = 0;
      case (m_mode)
        0: if (run && (m_may_start || !run)) m_mode = 1; else if (step && !run) m_mode = 2;
        1: if (halt_req || !run) m_mode = 3;
        default: if (m_end) m_mode = 0;
      endcase
    end
  end

  // Compare process: every cycle out of reset, DUT outputs against the model.
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      chk("phase1", phase1, m_p1);
      chk("phase2", phase2, m_p2);
      chk("en1", en1, m_e1);
      chk("en2", en2, m_e2);
      chk("busy", busy, m_mode != 0);
      chk("cfg_ready", cfg_if.cfg_ready, !m_has_next);
      chk("cfg_err", cfg_if.cfg_err, m_err);
`ifdef PERIOD_COUNT_EN
      chk("period_cnt", period_cnt, m_pc);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] d);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_div   = d;
    tick();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_en1(input int budget, input string name);
    int n = 0;
    do begin
      tick();
      n++;
    end while (en1 !== 1'b1 && n < budget);
    if (en1 !== 1'b1) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Called on the negedge showing en1; walks one period and checks its shape.
  task automatic measure(input int len, input int e_p1, input int e_p2, input int e_e2,
                         input string tag);
    int p1 = 0, p2 = 0, e2 = -1, e1n = 0;
    for (int i = 0; i < len; i++) begin
      p1 += int'(phase1);
      p2 += int'(phase2);
      if (en2 && e2 < 0) e2 = i;
      if (en1) e1n++;
      tick();
    end
    chk({tag, "_phase1_cycles"}, p1, e_p1);
    chk({tag, "_phase2_cycles"}, p2, e_p2);
    chk({tag, "_en2_offset"}, e2, e_e2);
    chk({tag, "_en1_count"}, e1n, 1);
    chk({tag, "_next_en1"}, en1, 1);
  endtask

  task automatic check_all_low(input string tag);
    chk({tag, "_phase1"}, phase1, 0);
    chk({tag, "_phase2"}, phase2, 0);
    chk({tag, "_en1"}, en1, 0);
    chk({tag, "_en2"}, en2, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cfg_err"}, cfg_if.cfg_err, 0);
    chk({tag, "_cfg_ready"}, cfg_if.cfg_ready, 1);
  endtask

  initial begin
    int b, e1c, e2c, p1c, p2c;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    #1 check_all_low("reset");
    tick();
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // Ratio below minimum in HALT: one-cycle error, nothing latched.
    offer(32'd1);
    chk("t3_err_pulse", cfg_if.cfg_err, 1);
    chk("t3_ready_kept", cfg_if.cfg_ready, 1);
    tick();
    chk("t3_err_cleared", cfg_if.cfg_err, 0);
    run = 1'b1;
    wait_en1(10, "t3_start");
    measure(100, 50, 75, 50, "t3_div100");

    // Reset released with run already high.
    @(negedge clk); #2 rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_en1(10, "t1_start");
    measure(100, 50, 75, 50, "t1");

    // Ratio 8 offered mid-period, takes effect on the next wrap.
    offer(32'd8);
    chk("t2_ready_low", cfg_if.cfg_ready, 0);
    wait_en1(200, "t2_wrap");
    chk("t2_ready_back", cfg_if.cfg_ready, 1);
    measure(8, 4, 6, 4, "t2");

    // Ratio 20, then halt_req seen at cnt=10 with run held high.
    offer(32'd20);
    wait_en1(20, "t5_sync");
    repeat (9) tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    b = 0; e1c = 0; p2c = 0; p1c = 0;
    for (int i = 0; i < 30; i++) begin
      b += int'(busy); e1c += int'(en1); p1c += int'(phase1); p2c += int'(phase2);
      tick();
    end
    chk("t5_busy_cycles", b, 9);
    chk("t5_en1_count", e1c, 0);
    chk("t5_phase1_cycles", p1c, 0);
    chk("t5_phase2_cycles", p2c, 5);
    run = 1'b0;
    tick();
    run = 1'b1;
    tick();
    chk("t5_restart", busy, 1);
    run = 1'b0;
    b = 0;
    while (busy && b < 50) begin tick(); b++; end
    chk("t5_stopped", busy, 0);

    // Ratio 4 in HALT, then a single step.
    offer(32'd4);
    tick();
    step = 1'b1;
    tick();
    step = 1'b0;
    b = 0; e1c = 0; e2c = 0; p1c = 0; p2c = 0;
    for (int i = 0; i < 12; i++) begin
      b += int'(busy); e1c += int'(en1); e2c += int'(en2);
      p1c += int'(phase1); p2c += int'(phase2);
      tick();
    end
    chk("t4_busy_cycles", b, 4);
    chk("t4_en1_count", e1c, 1);
    chk("t4_en2_count", e2c, 1);
    chk("t4_phase1_cycles", p1c, 2);
    chk("t4_phase2_cycles", p2c, 3);
    check_all_low("t4_end");

    // Reset mid-period with a ratio pending.
    offer(32'd64);
    tick();
    run = 1'b1;
    wait_en1(10, "t6_start");
    repeat (30) tick();
    chk("t6_phase1_at30", phase1, 1);
    offer(32'd8);
    chk("t6_pending", cfg_if.cfg_ready, 0);
    #2 rst_n = 1'b0;
    #1 check_all_low("t6_in_reset");
    tick();
    rst_n = 1'b1;
`ifdef PERIOD_COUNT_EN
    chk("t6_period_cnt", period_cnt, 0);
`endif
    wait_en1(10, "t6_restart");
    measure(100, 50, 75, 50, "t6_default");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
